booth_r2_mult_seq: RTL and testbench

- Parametrised sequential radix-2 Booth multiplier; the next generation of the team's fixed 4-bit Booth block.
- Adds operand width as a parameter and a per-operation signed/unsigned mode.
- Adds valid/ready handshakes on both input and output, with back-pressure and back-to-back issue.
- Sits between io/LA-driven operand registers and a result capture register in the user project wrapper.

---
 rtl/booth_r2_mult_seq.sv | 123 ++++++++++++
 tb/tb_booth_r2_mult_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r2_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready handshakes on both sides.
// Signed or unsigned operands are selected per operation; one Booth iteration runs per clock.
module booth_r2_mult_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   m_in,
  input  logic [WIDTH-1:0]   q_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t               state_q;
  logic [WIDTH+1:0]     a_q;
  logic [WIDTH:0]       q_q;
  logic [WIDTH:0]       m_q;
  logic                 qm1_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [WIDTH+1:0]     m_wide;
  logic [WIDTH+1:0]     a_sum;
  logic [WIDTH+1:0]     a_d;
  logic [WIDTH:0]       q_d;
  logic                 qm1_d;
  logic [CNT_W-1:0]     cnt_d;
  logic [2*WIDTH+2:0]   aq_d;
  logic [WIDTH:0]       m_ext_in;
  logic [WIDTH:0]       q_ext_in;
  logic                 accept;

  // in_ready is a function of state and out_ready only, never of in_valid
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = busy_q;

  assign m_ext_in = {in_signed & m_in[WIDTH-1], m_in};
  assign q_ext_in = {in_signed & q_in[WIDTH-1], q_in};

  always_comb begin
    m_wide = {m_q[WIDTH], m_q};
    a_sum  = a_q;
    case ({q_q[0], qm1_q})
      2'b10:   a_sum = a_q - m_wide;
      2'b01:   a_sum = a_q + m_wide;
      default: a_sum = a_q;
    endcase
    // Arithmetic shift of {A, Q, Q_-1} taken from the post-add accumulator
    a_d   = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
    q_d   = {a_sum[0], q_q[WIDTH:1]};
    qm1_d = q_q[0];
    cnt_d = cnt_q - CNT_LAST;
    aq_d  = {a_d, q_d};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      qm1_q       <= 1'b0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept) begin
      state_q     <= CALC;
      m_q         <= m_ext_in;
      q_q         <= q_ext_in;
      a_q         <= '0;
      qm1_q       <= 1'b0;
      cnt_q       <= CNT_INIT;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_d;
          if (cnt_q == CNT_LAST) begin
            product_q   <= aq_d[2*WIDTH-1:0];
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r2_mult_seq.sv
// Self-checking bench for booth_r2_mult_seq: a 4-bit and an 8-bit instance checked
// against an arithmetic reference model, covering handshakes, abort and reset.
module tb_booth_r2_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, clr;
  logic       inValid, inReady, inSigned, outValid, outReady, busy;
  logic [3:0] mIn, qIn;
  logic [7:0] product;

  logic        inValid8, inReady8, inSigned8, outValid8, outReady8, busy8;
  logic [7:0]  mIn8, qIn8;
  logic [15:0] product8;

  int errors = 0;
  int checks = 0;

  booth_r2_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(inValid), .in_ready(inReady), .in_signed(inSigned),
    .m_in(mIn), .q_in(qIn),
    .out_valid(outValid), .out_ready(outReady),
    .product(product), .busy(busy)
  );

  booth_r2_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(inValid8), .in_ready(inReady8), .in_signed(inSigned8),
    .m_in(mIn8), .q_in(qIn8),
    .out_valid(outValid8), .out_ready(outReady8),
    .product(product8), .busy(busy8)
  );

  // Plain integer multiplication, truncated to the 2*w-bit product width
  function automatic longint refMul(int w, bit s, longint m, longint q);
    longint mm = m;
    longint qq = q;
    longint mask;
    if (s) begin
      if (mm[w-1]) mm = mm - (longint'(1) << w);
      if (qq[w-1]) qq = qq - (longint'(1) << w);
    end
    mask = (longint'(1) << (2 * w)) - 1;
    return (mm * qq) & mask;
  endfunction

  task automatic start4(input bit s, input logic [3:0] m, input logic [3:0] q);
    inSigned = s;
    mIn      = m;
    qIn      = q;
    inValid  = 1'b1;
    @(negedge clk);
    inValid  = 1'b0;
  endtask

  task automatic waitDone4(output int lat, output int busyCycles);
    lat        = 0;
    busyCycles = 0;
    while (!outValid && lat < 40) begin
      if (busy) busyCycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire4();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 8'h00 || outValid !== 1'b0 || busy !== 1'b0 || product8 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_values: product=%h out_valid=%b busy=%b product8=%h, want 00/0/0/0000",
               product, outValid, busy, product8);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || inReady8 !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: in_ready=%b in_ready8=%b out_valid=%b, want 1/1/0",
               inReady, inReady8, outValid);
    end
  endtask

  task automatic test_directed();
    bit         sTab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] mTab [4] = '{4'h8, 4'hF, 4'hF, 4'h7};
    logic [3:0] qTab [4] = '{4'h8, 4'hF, 4'hF, 4'hD};
    logic [7:0] eTab [4] = '{8'h40, 8'hE1, 8'h01, 8'hEB};
    int lat, busyCycles;
    for (int i = 0; i < 4; i++) begin
      start4(sTab[i], mTab[i], qTab[i]);
      waitDone4(lat, busyCycles);
      checks++;
      if (product !== eTab[i]) begin
        errors++;
        $display("[TB] FAIL directed_product case %0d: got %h want %h", i, product, eTab[i]);
      end
      checks++;
      if (lat != 5 || busyCycles != 5) begin
        errors++;
        $display("[TB] FAIL directed_latency case %0d: latency=%0d busy=%0d want 5/5", i, lat, busyCycles);
      end
      retire4();
    end
  endtask

  task automatic test_exhaustive4();
    int lat, busyCycles;
    logic [7:0] expected;
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 16; m++) begin
        for (int q = 0; q < 16; q++) begin
          expected = 8'(refMul(4, s[0], longint'(m), longint'(q)));
          start4(s[0], 4'(m), 4'(q));
          waitDone4(lat, busyCycles);
          checks++;
          if (product !== expected || lat != 5) begin
            errors++;
            $display("[TB] FAIL exhaustive4 s=%0d m=%0d q=%0d: got %h lat=%0d want %h lat=5",
                     s, m, q, product, lat, expected);
          end
          retire4();
        end
      end
    end
  endtask

  task automatic test_random8();
    int lat;
    bit s;
    logic [7:0]  m, q;
    logic [15:0] expected;
    for (int i = 0; i < 3000; i++) begin
      s = 1'($urandom_range(1, 0));
      m = 8'($urandom);
      q = 8'($urandom);
      expected = 16'(refMul(8, s, longint'(m), longint'(q)));
      inSigned8 = s;
      mIn8      = m;
      qIn8      = q;
      inValid8  = 1'b1;
      @(negedge clk);
      inValid8  = 1'b0;
      lat = 0;
      while (!outValid8 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (product8 !== expected || lat != 9) begin
        errors++;
        $display("[TB] FAIL random8 s=%0d m=%h q=%h: got %h lat=%0d want %h lat=9",
                 s, m, q, product8, lat, expected);
      end
      outReady8 = 1'b1;
      @(negedge clk);
      outReady8 = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int lat, busyCycles;
    logic [7:0] oldProduct;
    oldProduct = 8'(refMul(4, 1'b0, 64'd9, 64'd11));
    start4(1'b0, 4'd9, 4'd11);
    waitDone4(lat, busyCycles);
    checks++;
    if (product !== oldProduct || lat != 5) begin
      errors++;
      $display("[TB] FAIL backpressure_first: got %h lat=%0d want %h lat=5", product, lat, oldProduct);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (product !== oldProduct || outValid !== 1'b1 || inReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL backpressure_hold cycle %0d: product=%h out_valid=%b in_ready=%b want %h/1/0",
                 i, product, outValid, inReady, oldProduct);
      end
    end
    inSigned = 1'b1;
    mIn      = 4'hB;
    qIn      = 4'h6;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    checks++;
    if (inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_in_ready: got %b want 1", inReady);
    end
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b0;
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b1 || product !== oldProduct) begin
      errors++;
      $display("[TB] FAIL b2b_retire: out_valid=%b busy=%b product=%h want 0/1/%h",
               outValid, busy, product, oldProduct);
    end
    waitDone4(lat, busyCycles);
    checks++;
    if (product !== 8'hE2 || lat != 5) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h lat=%0d want e2 lat=5", product, lat);
    end
    retire4();
  endtask

  task automatic test_churn();
    int lat;
    bit s;
    logic [3:0] m, q;
    logic [7:0] expected;
    for (int i = 0; i < 20; i++) begin
      s = 1'($urandom_range(1, 0));
      m = 4'($urandom);
      q = 4'($urandom);
      expected = 8'(refMul(4, s, longint'(m), longint'(q)));
      start4(s, m, q);
      lat = 0;
      while (!outValid && lat < 40) begin
        inSigned = 1'($urandom_range(1, 0));
        mIn      = 4'($urandom);
        qIn      = 4'($urandom);
        @(negedge clk);
        lat++;
      end
      checks++;
      if (product !== expected || lat != 5) begin
        errors++;
        $display("[TB] FAIL churn op %0d: got %h lat=%0d want %h lat=5", i, product, lat, expected);
      end
      retire4();
    end
  endtask

  task automatic test_clr();
    int lat, busyCycles;
    bit sawValid;
    logic [7:0] keep;
    keep = product;
    start4(1'b1, 4'd5, 4'hD);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (busy !== 1'b0 || outValid !== 1'b0 || inReady !== 1'b1 || product !== keep) begin
      errors++;
      $display("[TB] FAIL clr_abort: busy=%b out_valid=%b in_ready=%b product=%h want 0/0/1/%h",
               busy, outValid, inReady, product, keep);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (outValid || busy) sawValid = 1'b1;
    end
    checks++;
    if (sawValid !== 1'b0 || product !== keep) begin
      errors++;
      $display("[TB] FAIL clr_quiet: activity=%b product=%h want 0/%h", sawValid, product, keep);
    end
    inSigned = 1'b0;
    mIn      = 4'd3;
    qIn      = 4'd3;
    inValid  = 1'b1;
    clr      = 1'b1;
    @(negedge clk);
    inValid  = 1'b0;
    clr      = 1'b0;
    checks++;
    if (busy !== 1'b0 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_blocks_accept: busy=%b in_ready=%b want 0/1", busy, inReady);
    end
    start4(1'b1, 4'd5, 4'hD);
    waitDone4(lat, busyCycles);
    checks++;
    if (product !== 8'hF1 || lat != 5) begin
      errors++;
      $display("[TB] FAIL clr_recover: got %h lat=%0d want f1 lat=5", product, lat);
    end
    retire4();
  endtask

  task automatic test_async_reset();
    int lat, busyCycles;
    start4(1'b0, 4'd13, 4'd11);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (product !== 8'h00 || outValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: product=%h out_valid=%b busy=%b want 00/0/0", product, outValid, busy);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || product !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset_release: in_ready=%b out_valid=%b product=%h want 1/0/00",
               inReady, outValid, product);
    end
    start4(1'b0, 4'd13, 4'd11);
    waitDone4(lat, busyCycles);
    checks++;
    if (product !== 8'h8F || lat != 5) begin
      errors++;
      $display("[TB] FAIL async_reset_recover: got %h lat=%0d want 8f lat=5", product, lat);
    end
    retire4();
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    clr       = 1'b0;
    inValid   = 1'b0;
    inSigned  = 1'b0;
    mIn       = '0;
    qIn       = '0;
    outReady  = 1'b0;
    inValid8  = 1'b0;
    inSigned8 = 1'b0;
    mIn8      = '0;
    qIn8      = '0;
    outReady8 = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_exhaustive4();
    test_random8();
    test_back_to_back();
    test_churn();
    test_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
